exec_unit: RTL
==============

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have port clock, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port instr_i, input, 16 bits: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
REQ-004 SHALL have port instr_valid_i, input, 1 bit: instr_i holds a valid instruction.
REQ-005 SHALL have port instr_done_o, output, 1 bit: one-cycle pulse marking completion of the accepted instruction.
REQ-006 SHALL have port cf_o, output, 1 bit: carry/borrow flag, driven directly from the flag register to the fetch stage for the JMPS decision.
REQ-007 SHALL have port dbg_sel_i, input, 2 bits: selects a register for debug read.
REQ-008 SHALL have port dbg_data_o, output, 8 bits: combinational read of R[dbg_sel_i].

Function
REQ-009 SHALL contain four 8-bit registers R0-R3 and one flag register CF.
REQ-010 SHALL implement the FSM IDLE -> DECODE -> EXECUTE -> DONE -> IDLE, with one cycle per state.
REQ-011 IDLE SHALL latch instr_i and go to DECODE on the edge where instr_valid_i=1; otherwise it SHALL stay in IDLE.
REQ-012 DECODE SHALL capture R[rd] and R[rs] into operand latches; rd==rs is legal.
REQ-013 EXECUTE SHALL write the result to R[rd] and update CF on the exiting edge.
REQ-014 instr_done_o SHALL be 1 only in DONE: high for exactly one cycle, three cycles after the accept edge.
REQ-015 instr_valid_i SHALL be ignored in DECODE, EXECUTE and DONE; no back-to-back accept occurs without passing through IDLE.
REQ-016 Opcodes 0 NOP; 1 LDI rd=imm; 2 MOV rd=rs; 3 ADD rd=rd+rs; 4 SUB rd=rd-rs; 5 AND; 6 OR; 7 XOR; 8 SHL rd=rd<<1; 9 SHR rd=rd>>1 (logical).
REQ-017 Opcodes 10 CMP (no register write); 11 INC rd=rd+1; 12 DEC rd=rd-1; 13 JMPS, 14 JMP and 15 EOP execute as NOP but still produce instr_done_o.
REQ-018 All arithmetic SHALL be 8-bit unsigned with wrap-around; results truncate to 8 bits.
REQ-019 CF on ADD/INC: carry out of bit 7. On SUB/CMP/DEC: borrow, i.e. 1 iff minuend < subtrahend (unsigned). On SHL: old rd[7]. On SHR: old rd[0].
REQ-020 CF SHALL be unchanged by NOP, LDI, MOV, AND, OR, XOR, JMPS, JMP and EOP.
REQ-021 cf_o SHALL reflect the new CF from the first cycle of DONE.

Reset
REQ-022 reset=1 at an edge SHALL set the FSM to IDLE, R0-R3=0x00, CF=0, instr_done_o=0 and the latched instruction to 0x0000.
REQ-023 reset SHALL have priority over every transition; an in-flight instruction is discarded with no register write and no done pulse.
REQ-024 After reset deasserts, the first edge with instr_valid_i=1 SHALL be accepted.

Configuration
REQ-025 Macro EXEC_UNIT_ZERO_FLAG_EN SHALL control an extra output zf_o, 1 bit, plus a ZF register.
REQ-026 With EXEC_UNIT_ZERO_FLAG_EN defined: ZF=1 iff the 8-bit result == 0; it updates on ADD, SUB, AND, OR, XOR, SHL, SHR, CMP, INC and DEC, is unchanged otherwise, and resets to 0.
REQ-027 Without EXEC_UNIT_ZERO_FLAG_EN: zf_o and ZF SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Reset, then LDI R1,0x5A accepted at edge k -> instr_done_o=1 only in cycle k+3; dbg_sel=1 reads 0x5A; cf_o=0.
REQ-029 LDI R0,0xF0; LDI R1,0x20; ADD R0,R1 -> R0=0x10, cf_o=1; then ADD R0,R0 -> R0=0x20, cf_o=0.
REQ-030 R2=0x01, R3=0x02: SUB R2,R3 -> R2=0xFF, cf_o=1; then LDI R3,0xFF and CMP R2,R3 -> cf_o=0 with R2 unchanged; DEC of 0x00 -> 0xFF, cf_o=1.
REQ-031 reset asserted during EXECUTE of ADD R0,R1 (0x80+0x80) -> no done pulse, R0=0x00, cf_o=0, FSM in IDLE.
REQ-032 instr_valid_i held at 1 continuously over two instructions -> exactly one done pulse per accept, 4-cycle spacing, no double execution.
REQ-033 With EXEC_UNIT_ZERO_FLAG_EN defined: SUB R0,R0 -> R0=0x00, zf_o=1, cf_o=0; then LDI R0,0x00 -> zf_o stays 1.

Source files
------------

// File: rtl/exec_unit.sv
// exec_unit: four-state sequenced execution unit with four 8-bit registers,
// a carry/borrow flag and a combinational debug read port.
// Optional zero flag (zf_o plus its register) is built when the macro
// EXEC_UNIT_ZERO_FLAG_EN is defined; the default build omits it.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for instr_valid_i, latches instr_i on accept
// S_DECODE  | capture R[rd] and R[rs] into the operand latches
// S_EXECUTE | ALU result written to R[rd], flags updated on exit edge
// S_DONE    | instr_done_o high for this single cycle
module exec_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_done_o,
    output logic        cf_o,
    input  logic [1:0]  dbg_sel_i,
    output logic [7:0]  dbg_data_o
`ifdef EXEC_UNIT_ZERO_FLAG_EN
    ,
    output logic        zf_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_instr;
    logic [7:0]  r_regs [4];
    logic        r_cf;
    logic [7:0]  r_op_a;
    logic [7:0]  r_op_b;

    logic [3:0]  w_opcode;
    logic [1:0]  w_rd;
    logic [1:0]  w_rs;
    logic [7:0]  w_imm;
    logic [8:0]  w_sum;
    logic [7:0]  w_result;
    logic        w_wr_en;
    logic        w_cf_nxt;

    assign w_opcode = r_instr[15:12];
    assign w_rd     = r_instr[11:10];
    assign w_rs     = r_instr[9:8];
    assign w_imm    = r_instr[7:0];

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and done output
    always_comb begin
        w_state_nxt  = r_state;
        instr_done_o = 1'b0;
        case (r_state)
            S_IDLE:    if (instr_valid_i) w_state_nxt = S_DECODE;
            S_DECODE:  w_state_nxt = S_EXECUTE;
            S_EXECUTE: w_state_nxt = S_DONE;
            S_DONE: begin
                w_state_nxt  = S_IDLE;
                instr_done_o = 1'b1;
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // ALU: result, write enable and carry/borrow from the operand latches.
    // The 9-bit difference's top bit is exactly the unsigned borrow.
    always_comb begin
        w_sum    = 9'd0;
        w_result = r_op_a;
        w_wr_en  = 1'b0;
        w_cf_nxt = r_cf;
        case (w_opcode)
            4'd1: begin w_result = w_imm;  w_wr_en = 1'b1; end
            4'd2: begin w_result = r_op_b; w_wr_en = 1'b1; end
            4'd3: begin
                w_sum    = {1'b0, r_op_a} + {1'b0, r_op_b};
                w_result = w_sum[7:0];
                w_cf_nxt = w_sum[8];
                w_wr_en  = 1'b1;
            end
            4'd4, 4'd10: begin
                w_sum    = {1'b0, r_op_a} - {1'b0, r_op_b};
                w_result = w_sum[7:0];
                w_cf_nxt = w_sum[8];
                w_wr_en  = (w_opcode == 4'd4);
            end
            4'd5: begin w_result = r_op_a & r_op_b; w_wr_en = 1'b1; end
            4'd6: begin w_result = r_op_a | r_op_b; w_wr_en = 1'b1; end
            4'd7: begin w_result = r_op_a ^ r_op_b; w_wr_en = 1'b1; end
            4'd8: begin
                w_result = {r_op_a[6:0], 1'b0};
                w_cf_nxt = r_op_a[7];
                w_wr_en  = 1'b1;
            end
            4'd9: begin
                w_result = {1'b0, r_op_a[7:1]};
                w_cf_nxt = r_op_a[0];
                w_wr_en  = 1'b1;
            end
            4'd11: begin
                w_sum    = {1'b0, r_op_a} + 9'd1;
                w_result = w_sum[7:0];
                w_cf_nxt = w_sum[8];
                w_wr_en  = 1'b1;
            end
            4'd12: begin
                w_sum    = {1'b0, r_op_a} - 9'd1;
                w_result = w_sum[7:0];
                w_cf_nxt = w_sum[8];
                w_wr_en  = 1'b1;
            end
            default: ;
        endcase
    end

    // Instruction latch, operand capture, register file and carry flag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_instr <= 16'h0000;
            r_op_a  <= 8'h00;
            r_op_b  <= 8'h00;
            r_cf    <= 1'b0;
            for (int i = 0; i < 4; i++) r_regs[i] <= 8'h00;
        end else begin
            if (r_state == S_IDLE && instr_valid_i) r_instr <= instr_i;
            if (r_state == S_DECODE) begin
                r_op_a <= r_regs[w_rd];
                r_op_b <= r_regs[w_rs];
            end
            if (r_state == S_EXECUTE) begin
                if (w_wr_en) r_regs[w_rd] <= w_result;
                r_cf <= w_cf_nxt;
            end
        end
    end

`ifdef EXEC_UNIT_ZERO_FLAG_EN
    logic r_zf;
    logic w_zf_we;

    // Every opcode from ADD through DEC affects the zero flag, CMP included.
    assign w_zf_we = (w_opcode >= 4'd3) && (w_opcode <= 4'd12);

    // Zero flag register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_zf <= 1'b0;
        end else if (r_state == S_EXECUTE && w_zf_we) begin
            r_zf <= (w_result == 8'h00);
        end
    end

    assign zf_o = r_zf;
`endif

    assign cf_o       = r_cf;
    assign dbg_data_o = r_regs[dbg_sel_i];

endmodule
